// File: rtl/seq_ctrl.sv
// seq_ctrl: multi-cycle sequencer for the 8-bit accumulator CPU.
// Fetches from the instruction ROM, latches the IR, decodes the 3-bit opcode
// and drives the accumulator/PC strobes and a req/ack handshake to data RAM.
// Holds the Z/C flags and offers run/step/halt control to a debug host.
//
// Ports:
//   clk_i, rst_i             clock, synchronous active-high reset
//   run_i, step_i            debug run level / single-step pulse
//   halted_o                 1 while idle
//   ins_i                    ROM data at the current PC
//   ir_o                     latched instruction
//   pc_inc_o, pc_load_o      PC increment / load-from-operand strobes
//   mem_req_o, mem_we_o      data-RAM request and write enable
//   mem_addr_o, mem_ack_i    data-RAM address and completion
//   acc_wen_o                accumulator write strobe
//   alu_flag_z_i/_c_i        ALU flags for the current operation
//   flag_z_o, flag_c_o       registered flags
//   state_o                  current state encoding
//   retired_o                completed-instruction counter (wraps)
//
// state  | meaning
// IDLE   | halted, waiting for run or step
// FETCH  | latch ins_i into the IR
// DECODE | choose memory read, memory write or branch path
// MEMRD  | RAM read request until ack
// MEMWR  | RAM write request until ack; retires STA on the ack cycle
// EXEC   | accumulator/flag update or branch; retires the instruction

module seq_ctrl #(
  parameter int PC_W  = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             run_i,
  input  logic             step_i,
  output logic             halted_o,
  input  logic [7:0]       ins_i,
  output logic [7:0]       ir_o,
  output logic             pc_inc_o,
  output logic             pc_load_o,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic [PC_W-1:0]  mem_addr_o,
  input  logic             mem_ack_i,
  output logic             acc_wen_o,
  input  logic             alu_flag_z_i,
  input  logic             alu_flag_c_i,
  output logic             flag_z_o,
  output logic             flag_c_o,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] retired_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_MEMRD  = 3'd3,
    S_MEMWR  = 3'd4,
    S_EXEC   = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [7:0]       ir_q, ir_d;
  logic             step_q, step_d;
  logic             flag_z_q, flag_z_d;
  logic             flag_c_q, flag_c_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic [2:0] op;
  logic       is_jump;
  logic       take_branch;
  logic       in_exec;
  logic       wr_ack;
  logic       retire;

  assign op          = ir_q[7:5];
  assign is_jump     = op[2] & op[1];
  // JC is 111, JZ is 110: opcode bit 0 selects which flag is tested.
  assign take_branch = op[0] ? flag_c_q : flag_z_q;
  assign in_exec     = (state_q == S_EXEC);
  assign wr_ack      = (state_q == S_MEMWR) && mem_ack_i;
  assign retire      = in_exec || wr_ack;

  // Strobes are squelched during reset so an ack arriving with the reset
  // edge can never nudge the PC or the accumulator.
  assign pc_load_o  = !rst_i && in_exec && is_jump && take_branch;
  assign pc_inc_o   = !rst_i && (wr_ack || (in_exec && !(is_jump && take_branch)));
  assign acc_wen_o  = !rst_i && in_exec && !is_jump;
  assign mem_req_o  = !rst_i && ((state_q == S_MEMRD) || (state_q == S_MEMWR));
  assign mem_we_o   = !rst_i && (state_q == S_MEMWR);
  assign mem_addr_o = ir_q[PC_W-1:0];

  assign halted_o  = (state_q == S_IDLE) || rst_i;
  assign ir_o      = ir_q;
  assign flag_z_o  = flag_z_q;
  assign flag_c_o  = flag_c_q;
  assign state_o   = state_q;
  assign retired_o = retired_q;

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    step_d    = step_q;
    flag_z_d  = flag_z_q;
    flag_c_d  = flag_c_q;
    retired_d = retired_q;

    case (state_q)
      S_IDLE: begin
        if (run_i) begin
          state_d = S_FETCH;
          step_d  = 1'b0;
        end else if (step_i) begin
          state_d = S_FETCH;
          step_d  = 1'b1;
        end
      end
      S_FETCH: begin
        ir_d    = ins_i;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (op == 3'd5)  state_d = S_MEMWR;
        else if (is_jump) state_d = S_EXEC;
        else              state_d = S_MEMRD;
      end
      S_MEMRD: begin
        if (mem_ack_i) state_d = S_EXEC;
      end
      S_MEMWR: begin
        // leaving is handled by the common retire path below
      end
      S_EXEC: begin
        if (!is_jump) begin
          flag_z_d = alu_flag_z_i;
          flag_c_d = alu_flag_c_i;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A dropped run level lets the current instruction finish and halts here.
    if (retire) begin
      retired_d = retired_q + CNT_ONE;
      if (run_i && !step_q) begin
        state_d = S_FETCH;
      end else begin
        state_d = S_IDLE;
        step_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      ir_q      <= 8'h00;
      step_q    <= 1'b0;
      flag_z_q  <= 1'b0;
      flag_c_q  <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      step_q    <= step_d;
      flag_z_q  <= flag_z_d;
      flag_c_q  <= flag_c_d;
      retired_q <= retired_d;
    end
  end

endmodule

// File: tb/tb_seq_ctrl.sv
// Testbench for seq_ctrl: ROM/RAM environment model plus a retirement
// scoreboard (expected strobes pushed when a program is loaded, popped when
// the DUT retires an instruction) and directed timing checks.

module tb_seq_ctrl;

  localparam int PC_W = 5;
  localparam int CW   = 4;

  logic            clk = 1'b0;
  logic            rst_i = 1'b1;
  logic            run_i = 1'b0;
  logic            step_i = 1'b0;
  logic            halted_o;
  logic [7:0]      ins_i;
  logic [7:0]      ir_o;
  logic            pc_inc_o, pc_load_o;
  logic            mem_req_o, mem_we_o;
  logic [PC_W-1:0] mem_addr_o;
  logic            mem_ack_i = 1'b0;
  logic            acc_wen_o;
  logic            alu_flag_z_i, alu_flag_c_i;
  logic            flag_z_o, flag_c_o;
  logic [2:0]      state_o;
  logic [CW-1:0]   retired_o;

  always #5 clk = ~clk;

  seq_ctrl #(.PC_W(PC_W), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_i(rst_i), .run_i(run_i), .step_i(step_i),
    .halted_o(halted_o), .ins_i(ins_i), .ir_o(ir_o),
    .pc_inc_o(pc_inc_o), .pc_load_o(pc_load_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_ack_i(mem_ack_i), .acc_wen_o(acc_wen_o),
    .alu_flag_z_i(alu_flag_z_i), .alu_flag_c_i(alu_flag_c_i),
    .flag_z_o(flag_z_o), .flag_c_o(flag_c_o),
    .state_o(state_o), .retired_o(retired_o)
  );

  // environment: ROM addressed by the bench PC, ALU flags per operand address
  logic [7:0]  rom [32];
  logic [31:0] zt = '0;
  logic [31:0] ct = '0;
  logic [4:0]  pc = '0;
  int          ret_cnt = 0;
  int          wait_n = 0;
  int          wcnt = 0;

  assign ins_i        = rom[pc];
  assign alu_flag_z_i = zt[ir_o[4:0]];
  assign alu_flag_c_i = ct[ir_o[4:0]];

  typedef struct {
    logic       inc;
    logic       load;
    logic       wen;
    logic [2:0] st;
  } exp_t;
  exp_t sb[$];

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic exp_push(input logic inc, input logic load, input logic wen, input logic [2:0] st);
    exp_t e;
    e.inc = inc; e.load = load; e.wen = wen; e.st = st;
    sb.push_back(e);
  endtask

  // RAM responder: ack after wait_n request cycles, driven just after the edge
  always begin
    @(posedge clk);
    #1;
    if (mem_req_o) begin
      if (wcnt >= wait_n) mem_ack_i = 1'b1;
      else begin
        mem_ack_i = 1'b0;
        wcnt++;
      end
    end else begin
      mem_ack_i = 1'b0;
      wcnt = 0;
    end
  end

  // retirement monitor: pops the scoreboard and advances the bench PC
  always @(negedge clk) begin
    exp_t e;
    if (rst_i) begin
      pc = '0;
      ret_cnt = 0;
    end else begin
      if (pc_inc_o && pc_load_o) chk("inc_load_exclusive", 1, 0);
      if (pc_inc_o || pc_load_o) begin
        if (sb.size() == 0) chk("sb_unexpected_retire", 1, 0);
        else begin
          e = sb.pop_front();
          chk("sb_pc_inc", pc_inc_o, e.inc);
          chk("sb_pc_load", pc_load_o, e.load);
          chk("sb_acc_wen", acc_wen_o, e.wen);
          chk("sb_state", state_o, e.st);
        end
        ret_cnt++;
        if (pc_load_o) pc = ir_o[4:0];
        else pc = pc + 5'd1;
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    run_i = 1'b0;
    step_i = 1'b0;
    cyc();
    cyc();
    rst_i = 1'b0;
    sb.delete();
  endtask

  task automatic run_until_empty(input string tag, input int maxc);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < maxc; k++) begin
      cyc();
      if (sb.size() == 0) begin
        run_i = 1'b0;
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      chk({tag, "_timeout"}, 0, 1);
      run_i = 1'b0;
    end
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int  reqc, ackc, execc, n, wrc;
    bit  done, stepped, idle_seen;

    for (int i = 0; i < 32; i++) rom[i] = 8'h00;

    // ---- reset, then LDA 3 with immediate ack ----
    cyc();
    cyc();
    chk("rst_state", state_o, 0);
    chk("rst_halted", halted_o, 1);
    chk("rst_ir", ir_o, 0);
    chk("rst_retired", retired_o, 0);
    chk("rst_strobes", {pc_inc_o, pc_load_o, acc_wen_o, mem_req_o, mem_we_o}, 0);
    chk("rst_flags", {flag_z_o, flag_c_o}, 0);
    rst_i = 1'b0;
    rom[0] = 8'b100_00011;
    wait_n = 0;
    exp_push(1'b1, 1'b0, 1'b1, 3'd5);
    run_i = 1'b1;
    cyc();
    chk("t1_state_c1", state_o, 1);
    cyc();
    chk("t1_state_c2", state_o, 2);
    run_i = 1'b0;
    cyc();
    chk("t1_state_c3", state_o, 3);
    chk("t1_req", {mem_req_o, mem_we_o}, 2'b10);
    chk("t1_addr", mem_addr_o, 3);
    cyc();
    chk("t1_state_c4", state_o, 5);
    chk("t1_wen_inc", {acc_wen_o, pc_inc_o}, 2'b11);
    cyc();
    chk("t1_idle", state_o, 0);
    chk("t1_retired", retired_o, 1);

    // ---- ADD 6 with two wait cycles, run dropped during MEMRD ----
    do_reset();
    rom[0] = 8'b000_00110;
    zt[6] = 1'b1;
    ct[6] = 1'b1;
    wait_n = 2;
    exp_push(1'b1, 1'b0, 1'b1, 3'd5);
    run_i = 1'b1;
    reqc = 0; ackc = -1; execc = -1; n = 0; done = 1'b0;
    for (int k = 1; k <= 20 && !done; k++) begin
      cyc();
      if (state_o == 3'd3) run_i = 1'b0;
      if (mem_req_o) begin
        reqc++;
        chk("t2_addr_stable", mem_addr_o, 6);
        chk("t2_we_read", mem_we_o, 0);
        if (mem_ack_i) ackc = k;
      end
      if (state_o == 3'd5) execc = k;
      if (pc_inc_o) begin
        n = k;
        done = 1'b1;
      end
    end
    if (!done) chk("t2_timeout", 0, 1);
    chk("t2_req_cycles", reqc, 3);
    chk("t2_latency", n, 6);
    chk("t2_exec_after_ack", execc, ackc + 1);
    cyc();
    chk("t2_idle", state_o, 0);
    chk("t2_flags", {flag_z_o, flag_c_o}, 2'b11);
    chk("t2_retired", retired_o, 1);

    // ---- branches: SUB(Z=1,C=1), JZ taken, JC taken, OR(Z=0,C=0), JZ/JC not taken ----
    do_reset();
    for (int i = 0; i < 32; i++) rom[i] = 8'h00;
    rom[0]  = 8'b001_00001;  zt[1] = 1'b1; ct[1] = 1'b1;
    rom[1]  = 8'b110_01010;
    rom[10] = 8'b111_10100;
    rom[20] = 8'b011_00010;  zt[2] = 1'b0; ct[2] = 1'b0;
    rom[21] = 8'b110_00101;
    rom[22] = 8'b111_00101;
    wait_n = 0;
    exp_push(1'b1, 1'b0, 1'b1, 3'd5);
    exp_push(1'b0, 1'b1, 1'b0, 3'd5);
    exp_push(1'b0, 1'b1, 1'b0, 3'd5);
    exp_push(1'b1, 1'b0, 1'b1, 3'd5);
    exp_push(1'b1, 1'b0, 1'b0, 3'd5);
    exp_push(1'b1, 1'b0, 1'b0, 3'd5);
    run_i = 1'b1;
    run_until_empty("t3", 60);
    chk("t3_idle", state_o, 0);
    chk("t3_retired", retired_o, 6);
    chk("t3_pc", pc, 23);
    chk("t3_flags", {flag_z_o, flag_c_o}, 2'b00);

    // ---- single step STA 7, second step mid-instruction ignored ----
    do_reset();
    rom[0] = 8'b101_00111;
    wait_n = 1;
    exp_push(1'b1, 1'b0, 1'b0, 3'd4);
    step_i = 1'b1;
    cyc();
    step_i = 1'b0;
    chk("t4_fetch", state_o, 1);
    wrc = 0; stepped = 1'b0; idle_seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      cyc();
      step_i = 1'b0;
      if (state_o == 3'd0) begin
        idle_seen = 1'b1;
        break;
      end
      if (mem_req_o) begin
        wrc++;
        chk("t4_we", mem_we_o, 1);
        chk("t4_addr", mem_addr_o, 7);
        if (!stepped) begin
          step_i = 1'b1;
          stepped = 1'b1;
        end
      end
    end
    chk("t4_idle_reached", idle_seen, 1);
    chk("t4_req_cycles", wrc, 2);
    cyc();
    cyc();
    cyc();
    chk("t4_stays_idle", state_o, 0);
    chk("t4_retired", retired_o, 1);

    // ---- reset during a MEMWR wait ----
    do_reset();
    rom[0] = 8'b101_01001;
    wait_n = 50;
    exp_push(1'b1, 1'b0, 1'b0, 3'd4);
    run_i = 1'b1;
    done = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      if (state_o == 3'd4) begin
        done = 1'b1;
        break;
      end
    end
    chk("t5_reach_memwr", done, 1);
    cyc();
    chk("t5_req_held", {mem_req_o, mem_we_o}, 2'b11);
    rst_i = 1'b1;
    cyc();
    chk("t5_state", state_o, 0);
    chk("t5_req_dropped", mem_req_o, 0);
    chk("t5_no_inc", pc_inc_o, 0);
    chk("t5_halted", halted_o, 1);
    chk("t5_ir", ir_o, 0);
    rst_i = 1'b0;
    run_i = 1'b0;
    sb.delete();
    cyc();
    chk("t5_idle_after", state_o, 0);
    chk("t5_retired", retired_o, 0);

    // ---- self-loop JZ 1 and retired counter wrap (4-bit counter) ----
    do_reset();
    rom[0] = 8'b001_00001;
    rom[1] = 8'b110_00001;
    wait_n = 0;
    exp_push(1'b1, 1'b0, 1'b1, 3'd5);
    for (int i = 0; i < 16; i++) exp_push(1'b0, 1'b1, 1'b0, 3'd5);
    run_i = 1'b1;
    run_until_empty("t6", 200);
    chk("t6_idle", state_o, 0);
    chk("t6_ret_cnt", ret_cnt, 17);
    chk("t6_retired_wrap", retired_o, 1);
    chk("t6_pc", pc, 1);

    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
